// File: rtl/uart_tx_interface.sv
// rtl/uart_tx_interface.sv - byte FIFO feeding UART_TX via tx_start/tx_done handshake
// Optional trailing EOT byte (0x04) is enabled with UART_TX_IF_EOT_EN.
module uart_tx_interface #(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [7:0]            data_in,
   input  logic                  eot_req,
   input  logic                  tx_done,
   output logic                  tx_start,
   output logic [7:0]            tx_data,
   output logic                  busy,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic                  eot_sent
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [7:0] EOT_BYTE = 8'h04;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t state, state_next;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  push;
   logic                  pop;
   logic                  load_eot;

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);
   assign push  = wr_en && !full;

`ifdef UART_TX_IF_EOT_EN
   logic eot_pending;
   logic cur_eot;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Queued data always wins over a pending EOT, so late bytes precede it.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      load_eot   = 1'b0;
      tx_start   = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = START;
            end
`ifdef UART_TX_IF_EOT_EN
            else if (eot_pending) begin
               load_eot   = 1'b1;
               state_next = START;
            end
`endif
         end
         START: begin
            tx_start   = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (tx_done) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            tx_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1'b1;
         end else if (load_eot) begin
            tx_data <= EOT_BYTE;
         end
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (!push && pop) begin
            count <= count - 1'b1;
         end
      end
   end

`ifdef UART_TX_IF_EOT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         eot_pending <= 1'b0;
         cur_eot     <= 1'b0;
         eot_sent    <= 1'b0;
      end else begin
         eot_sent <= (state == WAIT) && tx_done && cur_eot;
         if (load_eot) begin
            eot_pending <= 1'b0;
         end else if (eot_req) begin
            eot_pending <= 1'b1;
         end
         if (pop) begin
            cur_eot <= 1'b0;
         end else if (load_eot) begin
            cur_eot <= 1'b1;
         end
      end
   end
`else
   logic unused_eot_req;
   assign unused_eot_req = eot_req;
   assign eot_sent       = 1'b0;
`endif

endmodule

// File: doc/uart_tx_interface.md
# uart_tx_interface

Transmit-side buffer between the Crypter (byte producer) and UART_TX. It queues bytes written by the producer in a small FIFO and feeds them one at a time to UART_TX through a start/done handshake. It holds the byte on `tx_data` until UART_TX reports completion. Optionally it appends an EOT byte (0x04) after the queue drains, matching the EOT convention used on the receive side.

## Interface

- `DEPTH_LOG2`, default 2: FIFO depth = 2^DEPTH_LOG2 entries of 8 bits; legal range 1..6.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  producer write strobe; `data_in` is queued when `wr_en` and `!full`.
- `data_in`  in  8  byte to transmit.
- `eot_req`  in  1  request EOT (0x04) after the queue drains; only active with `UART_TX_IF_EOT_EN`.
- `tx_done`  in  1  one-cycle tick from UART_TX: current byte fully shifted out.
- `tx_start`  out  1  one-cycle pulse to UART_TX: begin sending `tx_data`.
- `tx_data`  out  8  byte under transmission; stable from `tx_start` until `tx_done` is accepted.
- `busy`  out  1  high from the cycle after dispatch until the accepting `tx_done` edge.
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  DEPTH_LOG2+1  current FIFO occupancy.
- `overflow`  out  1  sticky; set when `wr_en` arrives while `full`; cleared only by `rst`.
- `eot_sent`  out  1  one-cycle pulse when `tx_done` is accepted for an EOT byte.

## Operation

- FIFO: circular buffer. Read and write pointers are DEPTH_LOG2 bits and wrap modulo depth. `count` is a separate register. `full` and `empty` are derived from registered `count`.
- Write acceptance uses the registered `full`. A write while full is dropped and sets `overflow`, even if a pop occurs in the same cycle.
- A simultaneous accepted write and pop leaves `count` unchanged.
- FSM states:
  - IDLE:
    - If `!empty`: pop the head into `tx_data`, clear `cur_eot`, go to START.
    - Else if `eot_pending`: load 0x04 into `tx_data`, set `cur_eot`, clear `eot_pending`, go to START.
    - Else: stay in IDLE.
  - START: `tx_start` = 1 for exactly this cycle; go to WAIT.
  - WAIT: `busy` = 1. On `tx_done`, go to IDLE; if `cur_eot`, pulse `eot_sent` in the next cycle.
- `tx_done` is ignored in IDLE and START.
- `tx_data` changes only on a dispatch edge.
- Reset values: `tx_start` 0, `tx_data` 0x00, `busy` 0, `full` 0, `empty` 1, `count` 0, `overflow` 0, `eot_sent` 0, FSM IDLE, pointers 0, `eot_pending` 0.
- Reset mid-transfer: queue and pending EOT are discarded. A late `tx_done` from UART_TX is then ignored because the FSM is in IDLE.

## Timing

- Write accepted at edge E0 into an empty FIFO with FSM in IDLE:
  - E1: dispatch; `count` returns to 0.
  - Cycle after E1: `tx_start` high.
  - E2: FSM enters WAIT; `busy` high from E2.
- `tx_done` accepted at edge Ek (WAIT → IDLE) with data queued:
  - Ek+1: next dispatch.
  - Cycle after Ek+1: `tx_start` high.
  - Minimum spacing between `tx_start` pulses is therefore one UART byte time plus 2 cycles.
- `eot_sent` is high in the cycle following the edge that accepts the EOT's `tx_done`.
- `tx_start` is never high in two consecutive cycles.

## Configuration

- `UART_TX_IF_EOT_EN` defined:
  - An `eot_req` pulse sets `eot_pending`; repeated requests while pending have no extra effect.
  - The EOT is dispatched only when the FSM is in IDLE and the FIFO is empty. Bytes written after `eot_req` but before the EOT dispatch are sent before the EOT.
- `UART_TX_IF_EOT_EN` undefined:
  - `eot_req` is ignored; `eot_pending` and `cur_eot` are absent; `eot_sent` is tied to 0.
  - Producer-written 0x04 bytes are sent as ordinary data in all builds.

## Test plan

- Single byte: write 0xA5 into empty FIFO.
  - `tx_start` pulses 2 cycles after the write edge with `tx_data`=0xA5.
  - `busy` stays high until `tx_done` is accepted.
  - `empty` is 1 one cycle after the write.
- Burst with DEPTH_LOG2=2: write 0x10,0x11,0x12,0x13,0x14,0x15 on consecutive cycles while UART_TX is slow (`tx_done` 20 cycles after each `tx_start`).
  - Required response: 0x10,0x11,0x12,0x13,0x14 transmitted in order.
  - 0x15 dropped, `overflow`=1, `count` peaks at 4 with `full`=1.
- Pointer wrap-around: 12 bytes 0x00..0x0B written in groups of 3, each group written after the previous drains.
  - Required response: all 12 bytes sent in order; `count` returns to 0 and `empty`=1 after each group.
- Spurious and early done: `tx_done` pulsed in IDLE and in the START cycle.
  - Required response: no state change.
  - Only a `tx_done` in WAIT advances the FSM.
- EOT (macro on): write 0x41,0x42, pulse `eot_req`, then write 0x43 before the EOT dispatches.
  - Required response: sent sequence 0x41,0x42,0x43,0x04.
  - `eot_sent` pulses once, after the 0x04's `tx_done`.
  - Macro off: sent sequence 0x41,0x42,0x43 only, and `eot_sent` stays 0.
- Reset mid-operation: `rst` asserted in WAIT with 3 bytes queued, then `tx_done` one cycle after reset releases.
  - Required response: all outputs at reset values.
  - No further `tx_start` occurs until a new write.
